// File: rtl/div_sequencer_if.sv
// Request/response bundle between the pipeline and the iterative divider.
// Latency: none, plain wires.
// Backpressure: in_valid/in_ready on the request side and out_valid/out_ready on the result side.
//
// Signals:
//   in_valid/in_ready  request handshake (master -> slave / slave -> master)
//   in1, in2, funct3   dividend, divisor, op select (4=DIV 5=DIVU 6=REM 7=REMU)
//   flush              synchronous abort from the pipeline
//   out_valid/out_ready result handshake (slave -> master / master -> slave)
//   out                quotient or remainder
//   busy               divider not idle
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       funct3;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;

    // Pipeline side: issues requests, consumes results.
    modport master (
        output in_valid, in1, in2, funct3, flush, out_ready,
        input  in_ready, out_valid, out, busy
    );

    // Divider side.
    modport slave (
        input  in_valid, in1, in2, funct3, flush, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/div_sequencer.sv
// Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU group.
// Latency: WIDTH+2 edges from accept (accept edge counted); div-by-zero/overflow/illegal in 1 edge when EARLY_OUT=1.
// Backpressure: in_ready only in IDLE without flush; result held in DONE until out_ready.
//
// Ports:
//   i_clk    clock, all state on posedge
//   i_rst    asynchronous reset, active low
//   io_bus   div_sequencer_if.slave: request/result handshakes, flush, busy
module div_sequencer #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    div_sequencer_if.slave  io_bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;        // partial remainder
    logic [WIDTH-1:0] r_quo;        // dividend shifts out the top, quotient bits shift in at the bottom
    logic [WIDTH-1:0] r_div;        // divisor magnitude
    logic             r_is_rem;     // 1: REM/REMU, 0: DIV/DIVU
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_spec;       // special case: result fixed at accept
    logic [WIDTH-1:0] r_spec_val;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_busy;

    // ------------------------------------------------------------------
    // Request decode (only meaningful on the accept edge)
    // ------------------------------------------------------------------
    logic             w_in_ready;
    logic             w_accept;
    logic             w_signed;
    logic             w_is_rem;
    logic             w_legal;
    logic             w_in1_neg;
    logic             w_in2_neg;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic             w_div0;
    logic             w_ovf;
    logic             w_spec;
    logic [WIDTH-1:0] w_spec_val;

    // Gating with the reset keeps in_ready low while the block is held in reset.
    assign w_in_ready = (r_state == S_IDLE) & ~io_bus.flush & i_rst;
    assign w_accept   = io_bus.in_valid & w_in_ready;

    // funct3[0]=0 selects the signed variants, funct3[1] selects remainder.
    assign w_signed   = ~io_bus.funct3[0];
    assign w_is_rem   = io_bus.funct3[1];
    assign w_legal    = io_bus.funct3[2];

    assign w_in1_neg  = w_signed & io_bus.in1[WIDTH-1];
    assign w_in2_neg  = w_signed & io_bus.in2[WIDTH-1];
    // |MIN| wraps to MIN, which is the correct magnitude when read unsigned.
    assign w_abs1     = w_in1_neg ? (~io_bus.in1 + 1'b1) : io_bus.in1;
    assign w_abs2     = w_in2_neg ? (~io_bus.in2 + 1'b1) : io_bus.in2;

    assign w_div0     = (io_bus.in2 == '0);
    assign w_ovf      = w_signed & (io_bus.in1 == MIN_VAL) & (io_bus.in2 == '1);
    assign w_spec     = ~w_legal | w_div0 | w_ovf;

    always_comb begin
        w_spec_val = '0;
        if (!w_legal) begin
            w_spec_val = '0;
        end else if (w_div0) begin
            w_spec_val = w_is_rem ? io_bus.in1 : '1;
        end else if (w_ovf) begin
            w_spec_val = w_is_rem ? '0 : MIN_VAL;
        end
    end

    // ------------------------------------------------------------------
    // One restoring step per CALC cycle
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_rem_t;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    assign w_rem_t = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_rem_t >= {1'b0, r_div});
    // When w_ge holds the true difference is below 2^WIDTH, so the low
    // WIDTH bits of the subtraction are exact.
    assign w_sub   = w_rem_t[WIDTH-1:0] - r_div;

    // ------------------------------------------------------------------
    // Sign fixup. A special case that ran the full sequence (EARLY_OUT=0)
    // still reports the architectural value captured at accept, since the
    // raw restoring result for a zero divisor is not sign-correct.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_fix;

    always_comb begin
        w_fix = '0;
        if (r_spec) begin
            w_fix = r_spec_val;
        end else if (r_is_rem) begin
            w_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;
        end else begin
            w_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_is_rem    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_spec      <= 1'b0;
            r_spec_val  <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (io_bus.flush) begin
            // Abort from any state. A result popped in the same cycle was
            // already taken by the consumer; only the state is discarded.
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem   <= w_is_rem;
                        r_neg_q    <= w_signed & ~w_is_rem & (io_bus.in1[WIDTH-1] ^ io_bus.in2[WIDTH-1]);
                        r_neg_r    <= w_signed &  w_is_rem &  io_bus.in1[WIDTH-1];
                        r_rem      <= '0;
                        r_quo      <= w_abs1;
                        r_div      <= w_abs2;
                        r_spec     <= w_spec;
                        r_spec_val <= w_spec_val;
                        r_cnt      <= CNT_INIT;
                        r_busy     <= 1'b1;
                        if (EARLY_OUT && w_spec) begin
                            r_out       <= w_spec_val;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state     <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    r_rem <= w_ge ? w_sub : w_rem_t[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= S_FIXUP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end

                S_FIXUP: begin
                    r_out       <= w_fix;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    // out is left untouched after the pop.
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out       = r_out;
    assign io_bus.busy      = r_busy;

endmodule
